// File: rtl/parity_frame_tx_if.sv
// Valid/ready handshake carrying the 9-bit parity-protected word
// from the parity encoder into the serial transmit stage.
interface parity_frame_tx_if;
  logic [8:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, 9 data bits LSB first, stop bit(s),
// with a one-entry holding register so consecutive frames run gap-free.
//
// state | meaning
// IDLE  | line high, waiting for the holding register to fill
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 9 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit(s) high; done on the final cycle
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  parity_frame_tx_if.slave   up,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc_cnt, cyc_n;
  logic [3:0]    bit_cnt, bit_n;
  logic          stop_idx, stop_n;
  logic [8:0]    shift, shift_n;
  logic          tx_n;
  logic          hold_full;
  logic [8:0]    hold_data;
  logic          drain;
  logic          cyc_last;

  // in_ready depends only on the holding flag, never on in_valid.
  assign up.in_ready = ~hold_full;
  assign busy        = (state != IDLE);
  assign cyc_last    = (cyc_cnt == CYC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (drain) begin
      hold_full <= 1'b0;
    end else if (up.in_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= up.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      cyc_cnt  <= cyc_n;
      bit_cnt  <= bit_n;
      stop_idx <= stop_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc_cnt;
    bit_n   = bit_cnt;
    stop_n  = stop_idx;
    shift_n = shift;
    tx_n    = tx;
    drain   = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (hold_full) begin
          shift_n = hold_data;
          drain   = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
          cyc_n   = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (cyc_last) begin
          cyc_n   = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          cyc_n = cyc_cnt + CW'(1);
        end
      end
      DATA: begin
        if (cyc_last) begin
          cyc_n = '0;
          if (bit_cnt == 4'd8) begin
            state_n = STOP;
            stop_n  = 1'b0;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_cnt + 4'd1;
            shift_n = {1'b0, shift[8:1]};
            tx_n    = shift[1];
          end
        end else begin
          cyc_n = cyc_cnt + CW'(1);
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (cyc_last) begin
          cyc_n = '0;
          if (stop_idx == STOP_LAST) begin
            done   = 1'b1;
            bit_n  = '0;
            stop_n = 1'b0;
            // A queued word starts its start bit on this same edge.
            if (hold_full) begin
              shift_n = hold_data;
              drain   = 1'b1;
              state_n = START;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            stop_n = 1'b1;
          end
        end else begin
          cyc_n = cyc_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboarded bench: words are queued on accept, a line monitor decodes
// frames from tx, and each scenario task pops and compares them.
module tb_parity_frame_tx;

  typedef struct {
    logic [8:0] word;
    bit         shape_ok;
    int         start_cycle;
    int         done_pos;
    int         done_cycle;
  } frame_t;

  logic clk;
  logic rst_n;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  int   cyc;
  int   done_cnt;
  int   checks;
  int   failures;

  logic [8:0] exp_q[$];
  logic [8:0] exp_b[$];
  frame_t     rx_q[$];

  parity_frame_tx_if ia();
  parity_frame_tx_if ib();

  parity_frame_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .up(ia), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  parity_frame_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .up(ib), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done_a === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Decodes one 44-cycle frame from dut_a, aborting if reset hits mid-frame.
  always begin : mon
    frame_t f;
    logic   ref_bit;
    bit     aborted;
    int     bp;
    @(negedge clk);
    if (rst_n === 1'b1 && tx_a === 1'b0) begin
      f.word = '0; f.shape_ok = 1'b1; f.start_cycle = cyc;
      f.done_pos = 0; f.done_cycle = 0;
      aborted = 1'b0; ref_bit = 1'b0;
      for (int c = 1; c <= 44; c++) begin
        if (c > 1) @(negedge clk);
        if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
        bp = (c - 1) / 4;
        if ((c - 1) % 4 == 0) begin
          ref_bit = tx_a;
          if (bp >= 1 && bp <= 9) f.word[bp-1] = tx_a;
        end
        if (tx_a !== ref_bit) f.shape_ok = 1'b0;
        if (bp == 0 && tx_a !== 1'b0) f.shape_ok = 1'b0;
        if (bp == 10 && tx_a !== 1'b1) f.shape_ok = 1'b0;
        if (busy_a !== 1'b1) f.shape_ok = 1'b0;
        if (done_a === 1'b1) begin
          if (f.done_pos == 0) begin f.done_pos = c; f.done_cycle = cyc; end
          else f.shape_ok = 1'b0;
        end
      end
      if (!aborted) rx_q.push_back(f);
    end
  end

  task automatic send(input bit sel, input logic [8:0] w, output int acc);
    acc = -1;
    if (sel) begin ib.in_data = w; ib.in_valid = 1'b1; end
    else     begin ia.in_data = w; ia.in_valid = 1'b1; end
    for (int i = 0; i < 400; i++) begin
      if ((sel ? ib.in_ready : ia.in_ready) === 1'b1) begin
        acc = cyc;
        if (sel) exp_b.push_back(w); else exp_q.push_back(w);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (sel) ib.in_valid = 1'b0; else ia.in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (rx_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ia.in_valid = 1'b1; ia.in_data = 9'h1AB;
    ib.in_valid = 1'b1; ib.in_data = 9'h0CD;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
    checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ia.in_ready); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
    checks++; if ({tx_b, ib.in_ready, busy_b, done_b} !== 4'b1100) begin
      failures++; $display("FAIL reset_b got=%b exp=1100", {tx_b, ib.in_ready, busy_b, done_b});
    end
    ia.in_valid = 1'b0; ib.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if ({tx_a, ia.in_ready, busy_a} !== 3'b110) begin
      failures++; $display("FAIL reset_no_accept got=%b exp=110", {tx_a, ia.in_ready, busy_a});
    end
  endtask

  task automatic test_single;
    int acc; bit ok; frame_t f; logic [8:0] e;
    send(1'b0, 9'h0EE, acc);
    wait_rx(1, ok);
    checks++; if (!ok || acc < 0) begin failures++; $display("FAIL single_timeout got=%0d exp=1", rx_q.size()); end
    else begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      checks++; if (f.word !== e) begin failures++; $display("FAIL single_word got=%h exp=%h", f.word, e); end
      checks++; if (!f.shape_ok) begin failures++; $display("FAIL single_shape got=0 exp=1"); end
      checks++; if (f.start_cycle !== acc + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", f.start_cycle, acc + 2); end
      checks++; if (f.done_pos !== 44) begin failures++; $display("FAIL single_done_pos got=%0d exp=44", f.done_pos); end
      while (cyc < f.start_cycle + 44) @(negedge clk);
      checks++; if ({busy_a, done_a, tx_a} !== 3'b001) begin
        failures++; $display("FAIL single_after got=%b exp=001", {busy_a, done_a, tx_a});
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc1, acc2, first_ready; bit ok; frame_t f0, f1; logic [8:0] e0, e1;
    send(1'b0, 9'h0EE, acc1);
    while (cyc < acc1 + 12) @(negedge clk);
    send(1'b0, 9'h1F8, acc2);
    first_ready = -1;
    for (int i = 0; i < 100; i++) begin
      if (ia.in_ready === 1'b1) begin first_ready = cyc; break; end
      @(negedge clk);
    end
    wait_rx(2, ok);
    checks++; if (!ok || acc2 < 0) begin failures++; $display("FAIL b2b_timeout got=%0d exp=2", rx_q.size()); end
    else begin
      f0 = rx_q.pop_front(); f1 = rx_q.pop_front();
      e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
      checks++; if (f0.word !== e0 || f1.word !== e1) begin
        failures++; $display("FAIL b2b_words got=%h,%h exp=%h,%h", f0.word, f1.word, e0, e1);
      end
      checks++; if (!(f0.shape_ok && f1.shape_ok)) begin failures++; $display("FAIL b2b_shape got=%b%b exp=11", f0.shape_ok, f1.shape_ok); end
      checks++; if (f1.start_cycle - f0.start_cycle !== 44) begin
        failures++; $display("FAIL b2b_gap got=%0d exp=44", f1.start_cycle - f0.start_cycle);
      end
      checks++; if (f1.done_cycle - f0.done_cycle !== 44) begin
        failures++; $display("FAIL b2b_done_spacing got=%0d exp=44", f1.done_cycle - f0.done_cycle);
      end
      checks++; if (first_ready !== f1.start_cycle) begin
        failures++; $display("FAIL b2b_ready_rise got=%0d exp=%0d", first_ready, f1.start_cycle);
      end
    end
  endtask

  task automatic test_backpressure;
    int a0, a1, a2; bit ok; frame_t f[3]; logic [8:0] e;
    send(1'b0, 9'h03C, a0);
    send(1'b0, 9'h1C3, a1);
    send(1'b0, 9'h100, a2);
    wait_rx(3, ok);
    checks++; if (!ok || a2 < 0) begin failures++; $display("FAIL bp_timeout got=%0d exp=3", rx_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) f[i] = rx_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        checks++; if (f[i].word !== e || !f[i].shape_ok) begin
          failures++; $display("FAIL bp_frame%0d got=%h ok=%b exp=%h", i, f[i].word, f[i].shape_ok, e);
        end
      end
      checks++; if (a2 !== f[1].start_cycle) begin failures++; $display("FAIL bp_third_accept got=%0d exp=%0d", a2, f[1].start_cycle); end
      checks++; if (f[2].start_cycle - f[0].start_cycle !== 88) begin
        failures++; $display("FAIL bp_spacing got=%0d exp=88", f[2].start_cycle - f[0].start_cycle);
      end
      repeat (60) @(negedge clk);
      checks++; if (rx_q.size() !== 0 || busy_a !== 1'b0) begin
        failures++; $display("FAIL bp_no_dup got=%0d busy=%b exp=0", rx_q.size(), busy_a);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int acc, d0; bit ok; frame_t f; logic [8:0] e;
    send(1'b0, 9'h0EE, acc);
    while (cyc < acc + 2 + 21) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      failures++; $display("FAIL mid_reset_async got=%b%b exp=10", tx_a, busy_a);
    end
    d0 = done_cnt;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    repeat (50) @(negedge clk);
    checks++; if (done_cnt !== d0 || rx_q.size() !== 0) begin
      failures++; $display("FAIL mid_reset_no_done got=%0d,%0d exp=%0d,0", done_cnt, rx_q.size(), d0);
    end
    send(1'b0, 9'h1F8, acc);
    wait_rx(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_reset_timeout got=%0d exp=1", rx_q.size()); end
    else begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      checks++; if (f.word !== e || !f.shape_ok || f.done_pos !== 44) begin
        failures++; $display("FAIL mid_reset_next got=%h ok=%b done=%0d exp=%h", f.word, f.shape_ok, f.done_pos, e);
      end
    end
  endtask

  task automatic test_stop2;
    int acc, tx_err, done_err, busy_err, bp; logic [8:0] w, got, e; logic eb;
    tx_err = 0; done_err = 0; busy_err = 0; got = '0;
    w = 9'h155;
    send(1'b1, w, acc);
    for (int c = 1; c <= 37; c++) begin
      if (c > 1 || cyc < acc + 2) @(negedge clk);
      bp = (c - 1) / 3;
      if (c <= 36) begin
        eb = (bp == 0) ? 1'b0 : (bp <= 9) ? w[bp-1] : 1'b1;
        if (tx_b !== eb) tx_err++;
        if (bp >= 1 && bp <= 9 && (c - 1) % 3 == 1) got[bp-1] = tx_b;
        if (done_b !== (c == 36)) done_err++;
        if (busy_b !== 1'b1) busy_err++;
      end else begin
        if (busy_b !== 1'b0 || tx_b !== 1'b1 || done_b !== 1'b0) busy_err++;
      end
    end
    checks++; if (tx_err != 0) begin failures++; $display("FAIL stop2_tx_seq got=%0d_bad exp=0", tx_err); end
    checks++; if (done_err != 0) begin failures++; $display("FAIL stop2_done_at_36 got=%0d_bad exp=0", done_err); end
    checks++; if (busy_err != 0) begin failures++; $display("FAIL stop2_length got=%0d_bad exp=0", busy_err); end
    e = exp_b.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL stop2_word got=%h exp=%h", got, e); end
  endtask

  initial begin
    cyc = 0; done_cnt = 0; checks = 0; failures = 0;
    rst_n = 1'b0;
    ia.in_valid = 1'b0; ia.in_data = '0;
    ib.in_valid = 1'b0; ib.in_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    repeat (5) @(negedge clk);
    test_back_to_back();
    repeat (60) @(negedge clk);
    test_backpressure();
    test_reset_mid_frame();
    repeat (10) @(negedge clk);
    test_stop2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
